// File: rtl/gru_pkg.sv
// Shared definitions for the GRU gate engine: FSM states, gate codes and
// fixed-point helpers used by the engine and its activation stage.
package gru_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC_X,
        MAC_H,
        DRAIN,
        ACT,
        OUT
    } gru_state_t;

    typedef enum logic [1:0] {
        GATE_RESET  = 2'd0,
        GATE_UPDATE = 2'd1,
        GATE_CAND   = 2'd2
    } gru_gate_t;

    function automatic int fx_one(input int frac_w);
        return 1 << frac_w;
    endfunction

    function automatic int fx_half(input int frac_w);
        return 1 << (frac_w - 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gru_act.sv
// Rounds the accumulator back to Q-format, saturates it, and applies hard
// sigmoid (reset/update gates) or hard tanh (candidate); result is registered.
module gru_act
    import gru_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [1:0]              gate,
    input  logic signed [ACC_W-1:0] acc,
    output logic [DATA_W-1:0]       act_out
);
    localparam int EXT_W = DATA_W + 2;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(fx_half(FRAC_W));
    localparam longint SAT_HI_L = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_HI_L);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-SAT_HI_L - 1);
    localparam logic signed [EXT_W-1:0] ONE_X  = EXT_W'(fx_one(FRAC_W));
    localparam logic signed [EXT_W-1:0] HALF_X = EXT_W'(fx_half(FRAC_W));

    logic signed [ACC_W-1:0] rounded;
    logic signed [EXT_W-1:0] pre;
    logic signed [EXT_W-1:0] lin;
    logic signed [EXT_W-1:0] lo;
    logic [DATA_W-1:0]       act_nxt;

    // Two guard bits above DATA_W keep pre/4 + 0.5 from overflowing before the clamp.
    always_comb begin
        rounded = (acc + RND) >>> FRAC_W;
        if (rounded > SAT_HI) begin
            pre = EXT_W'(SAT_HI);
        end else if (rounded < SAT_LO) begin
            pre = EXT_W'(SAT_LO);
        end else begin
            pre = EXT_W'(rounded);
        end

        if (gate == GATE_CAND) begin
            lin = pre;
            lo  = -ONE_X;
        end else begin
            lin = (pre >>> 2) + HALF_X;
            lo  = '0;
        end

        if (lin > ONE_X) begin
            act_nxt = DATA_W'(ONE_X);
        end else if (lin < lo) begin
            act_nxt = DATA_W'(lo);
        end else begin
            act_nxt = DATA_W'(lin);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_out <= '0;
        end else if (load) begin
            act_out <= act_nxt;
        end
    end

endmodule

// File: rtl/gru_gate_engine.sv
// Evaluates one GRU gate for every hidden unit: bias + W*x + U*h accumulated
// over external memories, then activated and handed out one unit at a time.
module gru_gate_engine
    import gru_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IN_DIM  = 42,
    parameter int HID_DIM = 24,
    parameter int ACC_W   = 40,
    localparam int MAX_DIM = max_int(IN_DIM, HID_DIM),
    localparam int VEC_AW  = clog2w(MAX_DIM),
    localparam int W_AW    = clog2w(3 * HID_DIM * MAX_DIM),
    localparam int B_AW    = clog2w(3 * HID_DIM),
    localparam int IDX_W   = clog2w(HID_DIM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        gate_sel,
    output logic              busy,
    output logic              done,
    output logic [VEC_AW-1:0] vec_addr,
    output logic              vec_sel,
    input  logic [DATA_W-1:0] vec_data,
    output logic [W_AW-1:0]   w_addr,
    output logic              w_rec,
    input  logic [DATA_W-1:0] w_data,
    output logic [B_AW-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
);
    gru_state_t state, state_nxt;

    logic [VEC_AW-1:0]          k;
    logic [IDX_W-1:0]           unit;
    logic [1:0]                 gate;
    logic                       accept;
    logic                       last_unit;
    logic                       bias_ld;
    logic                       data_vld;
    logic                       prod_vld;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    int                         dim;
    int                         row;

    // A start in the done cycle is refused so a back-to-back request cannot slip in.
    assign accept    = (state == IDLE) && start && !done;
    assign last_unit = (unit == IDX_W'(HID_DIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BIAS;
            BIAS:    state_nxt = MAC_X;
            MAC_X:   if (k == VEC_AW'(IN_DIM - 1)) state_nxt = MAC_H;
            MAC_H:   if (k == VEC_AW'(HID_DIM - 1)) state_nxt = DRAIN;
            DRAIN:   if (k == VEC_AW'(1)) state_nxt = ACT;
            ACT:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = last_unit ? IDLE : BIAS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= '0;
            unit <= '0;
            gate <= '0;
            done <= 1'b0;
        end else begin
            if (state != state_nxt) begin
                k <= '0;
            end else if (state == MAC_X || state == MAC_H || state == DRAIN) begin
                k <= k + VEC_AW'(1);
            end
            if (accept) begin
                gate <= (gate_sel == 2'd3) ? 2'd0 : gate_sel;
            end
            if (state == OUT && out_ready) begin
                unit <= last_unit ? '0 : unit + IDX_W'(1);
            end
            done <= (state == OUT) && out_ready && last_unit;
        end
    end

    // Memory data lags its address by one cycle, and the multiply adds one more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_ld  <= 1'b0;
            data_vld <= 1'b0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
        end else begin
            bias_ld  <= (state == BIAS);
            data_vld <= (state == MAC_X) || (state == MAC_H);
            prod_vld <= data_vld;
            if (data_vld) begin
                prod <= $signed(w_data) * $signed(vec_data);
            end
            if (bias_ld) begin
                acc <= {{(ACC_W-DATA_W-FRAC_W){b_data[DATA_W-1]}}, b_data, {FRAC_W{1'b0}}};
            end else if (prod_vld) begin
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            end
        end
    end

    always_comb begin
        dim      = (state == MAC_H) ? HID_DIM : IN_DIM;
        row      = int'(gate) * HID_DIM + int'(unit);
        w_addr   = W_AW'(row * dim + int'(k));
        b_addr   = B_AW'(row);
        vec_addr = k;
        vec_sel  = (state == MAC_H);
        w_rec    = (state == MAC_H);
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_idx   = unit;

    gru_act #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_act (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == ACT),
        .gate    (gate),
        .acc     (acc),
        .act_out (out_data)
    );

endmodule

// File: tb/tb_gru_gate_engine.sv
// Directed bench for gru_gate_engine with IN_DIM=4, HID_DIM=2 and
// behavioural x/h, weight and bias memories with one-cycle read latency.
module tb_gru_gate_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  gate_sel;
    logic        busy;
    logic        done;
    logic [1:0]  vec_addr;
    logic        vec_sel;
    logic [15:0] vec_data;
    logic [4:0]  w_addr;
    logic        w_rec;
    logic [15:0] w_data;
    logic [2:0]  b_addr;
    logic [15:0] b_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_idx;
    logic [15:0] out_data;

    logic [15:0] xmem [4];
    logic [15:0] hmem [4];
    logic [15:0] wx   [32];
    logic [15:0] wh   [32];
    logic [15:0] bm   [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gru_gate_engine #(
        .DATA_W  (16),
        .FRAC_W  (8),
        .IN_DIM  (4),
        .HID_DIM (2),
        .ACC_W   (40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gate_sel  (gate_sel),
        .busy      (busy),
        .done      (done),
        .vec_addr  (vec_addr),
        .vec_sel   (vec_sel),
        .vec_data  (vec_data),
        .w_addr    (w_addr),
        .w_rec     (w_rec),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    // Synchronous read memories feeding the engine.
    always @(posedge clk) begin
        vec_data <= vec_sel ? hmem[vec_addr] : xmem[vec_addr];
        w_data   <= w_rec ? wh[w_addr] : wx[w_addr];
        b_data   <= bm[b_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) begin
            xmem[i] = '0;
            hmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            wx[i] = '0;
            wh[i] = '0;
        end
        for (int i = 0; i < 8; i++) bm[i] = '0;
    endtask

    task automatic fill_uniform(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        clear_mem();
        for (int i = 0; i < 4; i++) xmem[i] = x;
        for (int i = 0; i < 32; i++) wx[i] = w;
        for (int i = 0; i < 8; i++) bm[i] = b;
    endtask

    // Called at a falling edge; runs one full gate evaluation and checks both units.
    task automatic apply_stimulus(input string tag, input logic [1:0] gate, input int stall,
                                  input bit poke, input logic [15:0] exp0, input logic [15:0] exp1);
        int stall_left;
        int done_edge;
        int exp_done;
        logic [1:0] seen;
        logic [1:0] eff_gate;
        stall_left = stall;
        done_edge  = -1;
        seen       = 2'b00;
        eff_gate   = (gate == 2'd3) ? 2'd0 : gate;
        exp_done   = (stall > 0) ? 21 + stall : 22;
        out_ready  = (stall == 0);
        gate_sel   = gate;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 5) begin
                start    = 1'b1;
                gate_sel = gate ^ 2'b10;
            end
            if (poke && k == 6) start = 1'b0;
            if (out_valid) begin
                if (out_idx == 1'b0 && !seen[0]) begin
                    check_output({tag, "_u0"}, 32'(out_data), 32'(exp0));
                    seen[0] = 1'b1;
                end else if (out_idx == 1'b1 && !seen[1]) begin
                    check_output({tag, "_u1"}, 32'(out_data), 32'(exp1));
                    seen[1] = 1'b1;
                end
                if (out_idx == 1'b0 && stall_left > 0) begin
                    check_output({tag, "_hold_data"}, 32'(out_data), 32'(exp0));
                    check_output({tag, "_hold_baddr"}, 32'(b_addr), 32'(eff_gate) * 2);
                    check_output({tag, "_hold_waddr"}, 32'(w_addr), 32'(eff_gate) * 8);
                    check_output({tag, "_hold_vaddr"}, 32'(vec_addr), 32'd0);
                    stall_left--;
                    if (stall_left == 0) out_ready = 1'b1;
                end
            end
            if (done) begin
                done_edge = k - 1;
                break;
            end
        end
        check_output({tag, "_units"}, 32'(seen), 32'd3);
        check_output({tag, "_done_at"}, 32'(done_edge), 32'(exp_done));
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output({tag, "_restart_ignored"}, 32'(busy), 32'd0);
        check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        gate_sel  = 2'd0;
        out_ready = 1'b1;
        vec_data  = '0;
        w_data    = '0;
        b_data    = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_waddr", 32'(w_addr), 32'd0);
        check_output("rst_baddr", 32'(b_addr), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        $display("[TB] zero inputs, reset gate, start mid-run ignored");
        apply_stimulus("zero", 2'd0, 0, 1'b1, 16'd128, 16'd128);

        $display("[TB] candidate gate, linear and clamped");
        fill_uniform(16'd256, 16'd32, 16'd0);
        apply_stimulus("cand_lin", 2'd2, 0, 1'b0, 16'd128, 16'd128);
        fill_uniform(16'd256, 16'd128, 16'd0);
        apply_stimulus("cand_clamp", 2'd2, 0, 1'b0, 16'd256, 16'd256);

        $display("[TB] bias extremes on update gate");
        fill_uniform(16'd0, 16'd0, 16'h7FFF);
        apply_stimulus("bias_max", 2'd1, 0, 1'b0, 16'd256, 16'd256);
        fill_uniform(16'd0, 16'd0, 16'h8000);
        apply_stimulus("bias_min", 2'd1, 0, 1'b0, 16'd0, 16'd0);

        $display("[TB] saturation of large products");
        fill_uniform(16'h7FFF, 16'h7FFF, 16'd0);
        apply_stimulus("sat_pos", 2'd2, 0, 1'b0, 16'd256, 16'd256);
        fill_uniform(16'h8000, 16'h7FFF, 16'd0);
        apply_stimulus("sat_neg", 2'd2, 0, 1'b0, 16'hFF00, 16'hFF00);

        $display("[TB] per-unit addressing with output stall");
        clear_mem();
        xmem[0] = 16'd64;
        hmem[0] = 16'hFF80;
        for (int i = 8; i < 12; i++) wx[i] = 16'd256;
        wh[6] = 16'd256;
        bm[3] = 16'd32;
        apply_stimulus("stall", 2'd1, 5, 1'b0, 16'd144, 16'd104);

        $display("[TB] rounding and negative clamp on candidate");
        clear_mem();
        wx[16]  = 16'd1;
        xmem[0] = 16'd128;
        bm[5]   = 16'hFED4;
        apply_stimulus("round", 2'd2, 0, 1'b0, 16'd1, 16'hFF00);

        $display("[TB] gate code 3 acts as reset gate");
        clear_mem();
        bm[0] = 16'd400;
        bm[1] = 16'hFFFC;
        apply_stimulus("gate3", 2'd3, 0, 1'b0, 16'd228, 16'd127);

        $display("[TB] reset during unit 1 accumulation");
        fill_uniform(16'd256, 16'd32, 16'd0);
        gate_sel = 2'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check_output("mid_vsel", 32'(vec_sel), 32'd0);
        check_output("mid_data", 32'(out_data), 32'd128);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_valid", 32'(out_valid), 32'd0);
        check_output("mid_rst_waddr", 32'(w_addr), 32'd0);
        check_output("mid_rst_baddr", 32'(b_addr), 32'd0);
        check_output("mid_rst_vaddr", 32'(vec_addr), 32'd0);
        check_output("mid_rst_idx", 32'(out_idx), 32'd0);
        check_output("mid_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("after_rst", 2'd2, 0, 1'b0, 16'd128, 16'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gru_gate_engine.md
GRU_GATE_ENGINE -- requirements
Module: gru_gate_engine

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, signed fixed-point word width; FRAC_W, default 8, fraction bits; IN_DIM, default 42, input vector length; HID_DIM, default 24, hidden units; ACC_W, default 40, accumulator width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports, clock and reset first:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one gate evaluation; sampled only in IDLE
gate_sel  in  2  0 = reset gate, 1 = update gate, 2 = candidate; 3 treated as 0; latched at start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last output handshake
vec_addr  out  clog2(max(IN_DIM,HID_DIM))  x/h element index
vec_sel  out  1  0 = x buffer, 1 = h buffer (upstream supplies r⊙h for candidate)
vec_data  in  DATA_W  element, valid 1 cycle after vec_addr
w_addr  out  clog2(3*HID_DIM*max(IN_DIM,HID_DIM))  (gate*HID_DIM + unit)*DIM + k
w_rec  out  1  0 = input-weight bank, 1 = recurrent-weight bank
w_data  in  DATA_W  weight, valid 1 cycle after w_addr
b_addr  out  clog2(3*HID_DIM)  gate*HID_DIM + unit
b_data  in  DATA_W  bias, valid 1 cycle after b_addr
out_valid  out  1  activated result available
out_ready  in  1  downstream accepts
out_idx  out  clog2(HID_DIM)  unit index of out_data
out_data  out  DATA_W  activated result, Q(DATA_W-FRAC_W).FRAC_W

Function
REQ-003 SHALL use FSM states IDLE, BIAS, MAC_X, MAC_H, DRAIN, ACT, OUT.
REQ-004 SHALL transition IDLE→BIAS on start; BIAS (1 cycle, issues b_addr)→MAC_X.
REQ-005 SHALL, in MAC_X, issue one address per cycle for k = 0..IN_DIM-1 (vec_sel=0, w_rec=0), then go to MAC_H.
REQ-006 SHALL, in MAC_H, issue k = 0..HID_DIM-1 (vec_sel=1, w_rec=1), then go to DRAIN (2 cycles), then ACT (1 cycle), then OUT.
REQ-007 SHALL initialise the accumulator to bias<<FRAC_W and add each full-precision product w*v (2*FRAC_W fraction) via a registered multiply stage.
REQ-008 SHALL, in ACT, compute pre = (acc + 2^(FRAC_W-1)) >>> FRAC_W and saturate it to the signed DATA_W range.
REQ-009 SHALL apply hard sigmoid clamp(pre/4 + 0.5, 0, 1.0) for gate_sel 0/1, and hard tanh clamp(pre, -1.0, 1.0) for gate_sel 2; pre/4 SHALL be an arithmetic shift.
REQ-010 SHALL hold out_valid, out_idx and out_data stable in OUT until out_ready; on handshake, go to BIAS for the next unit, or, after unit HID_DIM-1, go to IDLE and pulse done.
REQ-011 SHALL make each unit take IN_DIM+HID_DIM+5 cycles when out_ready is high.
REQ-012 SHALL ignore start while busy; start asserted in the cycle done pulses is ignored.
REQ-013 SHALL not allow accumulator wrap at the default ACC_W; products and sums are sign-extended.

Reset
REQ-014 SHALL, on rst_n low at any time (including mid-MAC or in OUT), force IDLE; busy, done and out_valid = 0; all addresses, out_idx, out_data and the accumulator = 0.
REQ-015 SHALL accept a fresh start in the first cycle after reset release.

Structure
REQ-016 SHALL place the FSM state encoding, gate_sel codes and fixed-point constants (ONE = 1<<FRAC_W, HALF) in shared package gru_pkg.
REQ-017 SHALL implement saturation and activation in one sub-module, gru_act, which is combinational with a registered output.

Verification (DATA_W=16, FRAC_W=8, IN_DIM=4, HID_DIM=2)
REQ-018 All weights, biases and vectors 0, gate_sel=0 → out_data 128 for units 0 and 1; done 2*(4+2+5) cycles after start.
REQ-019 gate_sel=2, x=256, W=32, h=0, bias 0 → pre 128, out_data 128; with W=128 → pre 512, out_data 256.
REQ-020 bias = 32767, gate_sel=1 → out_data 256; bias = -32768 → out_data 0; check saturation at 32767/-32768 with W=32767, x=32767.
REQ-021 out_ready low for 5 cycles on unit 0 → out_data, out_idx and addresses frozen, no extra bias read; unit 1 proceeds after the handshake.
REQ-022 rst_n low during MAC_X of unit 1 → all outputs 0 the same cycle; a new start after release produces correct results for both units.
